shift_rows_pipe: RTL and testbench

- Parametrised, pipelined ShiftRows / InvShiftRows unit for the AES/Rijndael datapath.
- Supports Rijndael block widths of 4, 6 or 8 columns (128/192/256 bits).
- Direction (forward or inverse) and bypass are selected per transaction.
- Provides a valid/ready stream interface with full backpressure, so it slots between the SubBytes and MixColumns stages of round pipelines.

---
 rtl/shift_rows_pipe.sv | 143 ++++++++++++++
 tb/tb_shift_rows_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// shift_rows_pipe
//
// Pipelined ShiftRows / InvShiftRows for a Rijndael state of NB columns
// (NB = 4, 6 or 8). Each beat selects its own direction or bypass. The
// byte permutation is pure wiring in front of stage 1. Stages 2..STAGES
// only add delay. A valid/ready handshake with full backpressure runs
// through the whole chain.
//
// State layout: byte (r,c) sits at bits [W-1-8*(4c+r) -: 8], column-major,
// with byte (0,0) as the MSB byte.
//
// Parameters
//   NB        number of state columns (4, 6 or 8); W = 32*NB
//   STAGES    register stages, 1..4; latency = STAGES cycles
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat present
//   in_ready   unit accepts a beat this cycle (combinational from out_ready)
//   in_inv     1 = InvShiftRows, 0 = ShiftRows, sampled with the beat
//   in_bypass  1 = pass the state unchanged; takes priority over in_inv
//   state_in   input state, W bits
//   out_valid  output beat present
//   out_ready  downstream accepts the output beat
//   state_out  transformed state; reads 0 whenever out_valid = 0
//   busy       OR of all stage valid flags
// -----------------------------------------------------------------------------
module shift_rows_pipe #(
   parameter int NB     = 4,
   parameter int STAGES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_inv,
   input  logic              in_bypass,
   input  logic [32*NB-1:0]  state_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [32*NB-1:0]  state_out,
   output logic              busy
);

   localparam int W = 32 * NB;

   // Reject unsupported configurations at elaboration time.
   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
   end
   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("shift_rows_pipe: STAGES must be in 1..4");
   end

   // -------------------------------------------------------------------------
   // Byte permutation. Every source index is an elaboration-time constant,
   // so the forward and inverse maps are fixed wiring. Only the final 3:1
   // select depends on the beat's mode.
   // -------------------------------------------------------------------------
   logic [W-1:0] fwd_w;
   logic [W-1:0] inv_w;
   logic [W-1:0] xform_w;

   genvar gi, gj;
   for (gi = 0; gi < 4; gi++) begin : g_row
      // The 256-bit block shifts rows 2 and 3 by one extra position.
      localparam int OFF = (NB == 8 && gi >= 2) ? gi + 1 : gi;
      for (gj = 0; gj < NB; gj++) begin : g_col
         localparam int SRC_F = (gj + OFF) % NB;
         localparam int SRC_I = (gj - OFF + NB) % NB;
         localparam int DST   = W - 1 - 8 * (4 * gj + gi);
         localparam int SF    = W - 1 - 8 * (4 * SRC_F + gi);
         localparam int SI    = W - 1 - 8 * (4 * SRC_I + gi);
         assign fwd_w[DST -: 8] = state_in[SF -: 8];
         assign inv_w[DST -: 8] = state_in[SI -: 8];
      end
   end

   assign xform_w = in_bypass ? state_in : (in_inv ? inv_w : fwd_w);

   // -------------------------------------------------------------------------
   // Stage chain. Stage 0 is nearest the input. valid_d/data_d hold the
   // value each stage would capture from its predecessor.
   // -------------------------------------------------------------------------
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;
   logic [STAGES-1:0] en_w;
   logic [W-1:0]      data_q [STAGES];
   logic [W-1:0]      data_d [STAGES];

   for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
         assign valid_d[gi] = in_valid;
         assign data_d[gi]  = xform_w;
      end else begin : g_next
         assign valid_d[gi] = valid_q[gi-1];
         assign data_d[gi]  = data_q[gi-1];
      end
   end

   // Load enables ripple back from out_ready. A stage may load when it is
   // empty or when its own contents move on in the same cycle. This is what
   // lets a full pipe accept and drain on the same edge.
   always_comb begin : p_enable
      logic adv;
      adv  = out_ready;
      en_w = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         en_w[k] = !valid_q[k] || adv;
         adv     = en_w[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (en_w[k]) begin
               valid_q[k] <= valid_d[k];
            end
         end
      end
   end

   // Data registers need no reset because the output is masked by out_valid.
   // A register captures only a real beat, which avoids toggling on bubbles.
   always_ff @(posedge clk) begin
      for (int k = 0; k < STAGES; k++) begin
         if (en_w[k] && valid_d[k]) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   assign in_ready  = en_w[0];
   assign out_valid = valid_q[STAGES-1];
   assign state_out = valid_q[STAGES-1] ? data_q[STAGES-1] : '0;
   assign busy      = |valid_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_rows_pipe
//
// Bench for shift_rows_pipe with three instances:
//   u4 : NB=4, STAGES=1
//   u8 : NB=8, STAGES=2
//   u6 : NB=6, STAGES=3
// Known vectors run from a table. Streams of random beats on u6 are scored
// against a byte-level reference of the row rotation. A mid-stream reset
// is exercised by hand.
// -----------------------------------------------------------------------------
module tb_shift_rows_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // u4
   logic         i4_valid, i4_ready, i4_inv, i4_byp, o4_valid, o4_ready, o4_busy;
   logic [127:0] i4_din, o4_dout;
   // u8
   logic         i8_valid, i8_ready, i8_inv, i8_byp, o8_valid, o8_ready, o8_busy;
   logic [255:0] i8_din, o8_dout;
   // u6
   logic         i6_valid, i6_ready, i6_inv, i6_byp, o6_valid, o6_ready, o6_busy;
   logic [191:0] i6_din, o6_dout;

   shift_rows_pipe #(.NB(4), .STAGES(1)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(i4_valid), .in_ready(i4_ready),
      .in_inv(i4_inv), .in_bypass(i4_byp), .state_in(i4_din),
      .out_valid(o4_valid), .out_ready(o4_ready), .state_out(o4_dout), .busy(o4_busy));

   shift_rows_pipe #(.NB(8), .STAGES(2)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(i8_valid), .in_ready(i8_ready),
      .in_inv(i8_inv), .in_bypass(i8_byp), .state_in(i8_din),
      .out_valid(o8_valid), .out_ready(o8_ready), .state_out(o8_dout), .busy(o8_busy));

   shift_rows_pipe #(.NB(6), .STAGES(3)) u6 (
      .clk(clk), .rst_n(rst_n), .in_valid(i6_valid), .in_ready(i6_ready),
      .in_inv(i6_inv), .in_bypass(i6_byp), .state_in(i6_din),
      .out_valid(o6_valid), .out_ready(o6_ready), .state_out(o6_dout), .busy(o6_busy));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: rotate each row of a column-major byte matrix. Row r moves
   // left by off(r) for the forward map and right by off(r) for the inverse.
   function automatic logic [255:0] ref_sr(input logic [255:0] s, input int nb,
                                           input logic inv, input logic byp);
      logic [255:0] r;
      int off [4];
      int w;
      int src;
      r = '0;
      w = 32 * nb;
      off[0] = 0;
      off[1] = 1;
      off[2] = (nb == 8) ? 3 : 2;
      off[3] = (nb == 8) ? 4 : 3;
      if (byp) return s;
      for (int c = 0; c < nb; c++) begin
         for (int row = 0; row < 4; row++) begin
            src = inv ? (c - off[row] + nb) % nb : (c + off[row]) % nb;
            r[w-1-8*(4*c+row) -: 8] = s[w-1-8*(4*src+row) -: 8];
         end
      end
      return r;
   endfunction

   task automatic set_in(input int nb, input logic v, input logic [255:0] d,
                         input logic inv, input logic byp);
      case (nb)
         4: begin i4_valid = v; i4_din = d[127:0]; i4_inv = inv; i4_byp = byp; end
         8: begin i8_valid = v; i8_din = d;        i8_inv = inv; i8_byp = byp; end
         default: begin i6_valid = v; i6_din = d[191:0]; i6_inv = inv; i6_byp = byp; end
      endcase
   endtask

   function automatic logic [255:0] get_out(input int nb);
      case (nb)
         4:       return {128'b0, o4_dout};
         8:       return o8_dout;
         default: return {64'b0, o6_dout};
      endcase
   endfunction

   function automatic logic get_ov(input int nb);
      case (nb)
         4:       return o4_valid;
         8:       return o8_valid;
         default: return o6_valid;
      endcase
   endfunction

   function automatic logic get_ir(input int nb);
      case (nb)
         4:       return i4_ready;
         8:       return i8_ready;
         default: return i6_ready;
      endcase
   endfunction

   function automatic logic get_busy(input int nb);
      case (nb)
         4:       return o4_busy;
         8:       return o8_busy;
         default: return o6_busy;
      endcase
   endfunction

   // One isolated beat with out_ready=1. The result must show up exactly
   // STAGES cycles after the accept edge and be gone on the next edge.
   task automatic single_beat(input int nb, input logic [255:0] din, input logic inv,
                              input logic byp, input logic [255:0] exp, input string name);
      int lat;
      lat = (nb == 4) ? 1 : (nb == 8) ? 2 : 3;
      @(negedge clk);
      set_in(nb, 1'b1, din, inv, byp);
      #1;
      check({name, "_in_ready"}, {255'b0, get_ir(nb)}, 256'd1);
      @(posedge clk);
      #1;
      set_in(nb, 1'b0, '0, 1'b0, 1'b0);
      for (int k = 1; k < lat; k++) begin
         check({name, "_early_valid"}, {255'b0, get_ov(nb)}, 256'd0);
         @(posedge clk);
         #1;
      end
      check({name, "_out_valid"}, {255'b0, get_ov(nb)}, 256'd1);
      check({name, "_state_out"}, get_out(nb), exp);
      $display("beat %s nb=%0d inv=%0b byp=%0b out=%h", name, nb, inv, byp, get_out(nb));
      @(posedge clk);
      #1;
      check({name, "_drained"}, {255'b0, get_ov(nb)}, 256'd0);
   endtask

   // Streams beats into u6 (3 stages) with in_valid held high and out_ready
   // high with probability rdy_pct. Data and mode are re-randomised every
   // cycle, so only the values present at the accept edge may count.
   task automatic stream6(input int nbeats, input int rdy_pct, input string tag);
      logic [191:0] q_exp [$];
      int           q_acc [$];
      int           sent, got, cyc, occ;
      logic         prev_stall, acc, drn, exp_ov;
      logic [191:0] prev_out;
      sent = 0; got = 0; cyc = 0; occ = 0;
      prev_stall = 1'b0;
      prev_out = '0;
      while (got < nbeats && cyc < nbeats * 10 + 100) begin
         @(negedge clk);
         o6_ready = ($urandom_range(1, 100) <= rdy_pct);
         i6_valid = (sent < nbeats);
         i6_din   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         i6_inv   = 1'($urandom_range(0, 1));
         i6_byp   = ($urandom_range(0, 2) == 0);
         #1;
         if (prev_stall) begin
            check({tag, "_stall_valid"}, {255'b0, o6_valid}, 256'd1);
            check({tag, "_stall_hold"}, {64'b0, o6_dout}, {64'b0, prev_out});
         end
         check({tag, "_in_ready"}, {255'b0, i6_ready}, {255'b0, !(occ == 3 && !o6_ready)});
         check({tag, "_busy"}, {255'b0, o6_busy}, {255'b0, occ > 0});
         // The oldest beat never waits on anything ahead of it, so it must
         // reach the output exactly 3 cycles after acceptance.
         exp_ov = (q_acc.size() > 0) && (cyc - q_acc[0] >= 3);
         check({tag, "_out_valid"}, {255'b0, o6_valid}, {255'b0, exp_ov});
         if (o6_valid && q_exp.size() > 0) begin
            check({tag, "_data"}, {64'b0, o6_dout}, {64'b0, q_exp[0]});
         end
         acc = i6_valid && i6_ready;
         drn = o6_valid && o6_ready;
         prev_stall = o6_valid && !o6_ready;
         prev_out = o6_dout;
         @(posedge clk);
         if (acc) begin
            q_exp.push_back(ref_sr({64'b0, i6_din}, 6, i6_inv, i6_byp)[191:0]);
            q_acc.push_back(cyc);
            sent++;
            occ++;
         end
         if (drn && q_exp.size() > 0) begin
            $display("beat %s #%0d out=%h", tag, got, o6_dout);
            void'(q_exp.pop_front());
            void'(q_acc.pop_front());
            got++;
            occ--;
         end
         cyc++;
      end
      check({tag, "_all_beats_out"}, 256'(got), 256'(nbeats));
      // Nothing may emerge after the last beat.
      @(negedge clk);
      i6_valid = 1'b0;
      o6_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check({tag, "_no_extra"}, {255'b0, o6_valid}, 256'd0);
         @(negedge clk);
      end
      check({tag, "_idle_busy"}, {255'b0, o6_busy}, 256'd0);
      $display("stream %s beats=%0d cycles=%0d", tag, got, cyc);
   endtask

   typedef struct {
      int           nb;
      logic [255:0] din;
      logic         inv;
      logic         byp;
      logic [255:0] exp;
   } vec_t;

   vec_t tbl [8];

   localparam logic [255:0] SEQ16  = 256'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] FWD16  = 256'h00050a0f04090e03080d02070c01060b;
   localparam logic [255:0] INV16  = 256'h000d0a0704010e0b0805020f0c090603;
   localparam logic [255:0] SEQ32  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] FWD32  = 256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;

   initial begin
      logic [255:0] rv;

      i4_valid = 0; i4_inv = 0; i4_byp = 0; i4_din = '0; o4_ready = 1;
      i8_valid = 0; i8_inv = 0; i8_byp = 0; i8_din = '0; o8_ready = 1;
      i6_valid = 0; i6_inv = 0; i6_byp = 0; i6_din = '0; o6_ready = 1;

      tbl[0] = '{4, SEQ16, 1'b0, 1'b0, FWD16};
      tbl[1] = '{4, SEQ16, 1'b1, 1'b0, INV16};
      tbl[2] = '{4, FWD16, 1'b1, 1'b0, SEQ16};
      tbl[3] = '{4, INV16, 1'b0, 1'b0, SEQ16};
      tbl[4] = '{4, SEQ16, 1'b1, 1'b1, SEQ16};
      tbl[5] = '{8, SEQ32, 1'b0, 1'b0, FWD32};
      tbl[6] = '{8, FWD32, 1'b1, 1'b0, SEQ32};
      tbl[7] = '{8, SEQ32, 1'b0, 1'b1, SEQ32};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int n = 4; n <= 8; n += 2) begin
         check($sformatf("reset_out_valid_nb%0d", n), {255'b0, get_ov(n)}, 256'd0);
         check($sformatf("reset_busy_nb%0d", n), {255'b0, get_busy(n)}, 256'd0);
         check($sformatf("reset_in_ready_nb%0d", n), {255'b0, get_ir(n)}, 256'd1);
         check($sformatf("reset_state_out_nb%0d", n), get_out(n), 256'd0);
      end

      for (int i = 0; i < 8; i++) begin
         single_beat(tbl[i].nb, tbl[i].din, tbl[i].inv, tbl[i].byp, tbl[i].exp,
                     $sformatf("vec%0d", i));
      end

      // A hand-picked NB=6 beat of each mode, checked against the reference.
      rv = {64'b0, SEQ32[191:0]};
      single_beat(6, rv, 1'b0, 1'b0, ref_sr(rv, 6, 1'b0, 1'b0), "nb6_fwd");
      single_beat(6, rv, 1'b1, 1'b0, ref_sr(rv, 6, 1'b1, 1'b0), "nb6_inv");
      single_beat(6, rv, 1'b1, 1'b1, rv, "nb6_byp");

      stream6(10, 50, "stall");
      stream6(200, 30, "heavy_stall");
      stream6(1000, 100, "rand");

      // Reset with two beats in flight, the older one already on the output.
      @(negedge clk);
      o6_ready = 1'b0;
      set_in(6, 1'b1, {64'b0, 192'h1111}, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      set_in(6, 1'b1, {64'b0, 192'h2222}, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      set_in(6, 1'b0, '0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("rst_pre_out_valid", {255'b0, o6_valid}, 256'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_out_valid", {255'b0, o6_valid}, 256'd0);
      check("rst_async_busy", {255'b0, o6_busy}, 256'd0);
      check("rst_async_state_out", {64'b0, o6_dout}, 256'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      o6_ready = 1'b1;
      #1;
      check("rst_post_in_ready", {255'b0, i6_ready}, 256'd1);
      check("rst_post_out_valid", {255'b0, o6_valid}, 256'd0);
      rv = {64'b0, 192'hfedcba9876543210_0123456789abcdef_55aa33cc0ff0f00f};
      single_beat(6, rv, 1'b1, 1'b0, ref_sr(rv, 6, 1'b1, 1'b0), "rst_first_beat");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
